// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  // Requester IDs double as bit positions in the req/grant vectors.
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  // Bytes carried by one request from each requester.
  localparam int BYTES_A = 1;
  localparam int BYTES_B = 2;

  // bytes_left counts the bytes still to send after the current one.
  function automatic logic bytes_left_init(input int bytes);
    return (bytes > 1);
  endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant when enabled, registered last winner.
// Latency: grant is combinational from req_i/en_i; last_grant_o updates on the grant edge.
// Backpressure: en_i low suppresses every grant and freezes last_grant_o.
module rr_arb2
  import uart_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o,
  output logic       last_grant_o
);

  logic last_grant_q;
  logic last_grant_d;

  // Lone request wins; on a tie the requester that did not win last time goes first.
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_i[REQ_A] && req_i[REQ_B]) begin
        if (last_grant_q == REQ_B) gnt_o[REQ_A] = 1'b1;
        else                       gnt_o[REQ_B] = 1'b1;
      end else if (req_i[REQ_A]) begin
        gnt_o[REQ_A] = 1'b1;
      end else if (req_i[REQ_B]) begin
        gnt_o[REQ_B] = 1'b1;
      end
    end
  end

  // Remember whoever was granted so the next tie goes the other way.
  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt_o[REQ_A])      last_grant_d = REQ_A;
    else if (gnt_o[REQ_B]) last_grant_d = REQ_B;
  end

  // Reset to B so that A wins the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_grant_q <= REQ_B;
    else      last_grant_q <= last_grant_d;
  end

  assign last_grant_o = last_grant_q;

endmodule

// File: rtl/uart_tx_sched.sv
// Schedules 1-byte (A) and 2-byte (B) requests onto a single UART transmitter.
// Latency: strobe and ack 1 cycle after a valid is sampled in IDLE; 1-cycle gap between bytes of B.
// Backpressure: waits for tx_busy to rise then fall after each strobe; requesters hold valid until ack.
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_valid,
  input  logic [DATA_WIDTH-1:0]   a_data,
  output logic                    a_ack,
  input  logic                    b_valid,
  input  logic [2*DATA_WIDTH-1:0] b_data,
  output logic                    b_ack,
  input  logic                    tx_busy,
  output logic                    tx_data_valid,
  output logic [DATA_WIDTH-1:0]   tx_p_data,
  output logic                    sched_busy
);

  state_t                state_q;
  logic [DATA_WIDTH-1:0] byte_q;        // byte currently presented to the UART
  logic [DATA_WIDTH-1:0] payload_hi_q;  // second byte of a B request
  logic                  bytes_left_q;
  logic                  first_q;       // LOAD entered straight from a grant
  logic [1:0]            gnt;
  logic                  last_grant;
  logic                  grant_en;

  // New requests are only considered while idle.
  assign grant_en = (state_q == IDLE);

  rr_arb2 u_arb (
    .clk          (clk),
    .rst          (rst),
    .req_i        ({b_valid, a_valid}),
    .en_i         (grant_en),
    .gnt_o        (gnt),
    .last_grant_o (last_grant)
  );

  // Scheduler FSM: grant, strobe a byte, ride out the UART busy pulse, repeat for B's high byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      byte_q       <= '0;
      payload_hi_q <= '0;
      bytes_left_q <= 1'b0;
      first_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt[REQ_A]) begin
            byte_q       <= a_data;
            payload_hi_q <= '0;
            bytes_left_q <= bytes_left_init(BYTES_A);
            first_q      <= 1'b1;
            state_q      <= LOAD;
          end else if (gnt[REQ_B]) begin
            byte_q       <= b_data[DATA_WIDTH-1:0];
            payload_hi_q <= b_data[2*DATA_WIDTH-1:DATA_WIDTH];
            bytes_left_q <= bytes_left_init(BYTES_B);
            first_q      <= 1'b1;
            state_q      <= LOAD;
          end
        end
        LOAD: begin
          first_q <= 1'b0;
          state_q <= WAIT_HI;
        end
        WAIT_HI: begin
          // A busy flag already high at entry is absorbed here.
          if (tx_busy) state_q <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!tx_busy) begin
            if (bytes_left_q) begin
              byte_q       <= payload_hi_q;
              bytes_left_q <= 1'b0;
              state_q      <= LOAD;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // All outputs decode registered state; last_grant names the requester just granted.
  assign tx_data_valid = (state_q == LOAD);
  assign sched_busy    = (state_q != IDLE);
  assign tx_p_data     = byte_q;
  assign a_ack         = (state_q == LOAD) && first_q && (last_grant == REQ_A);
  assign b_ack         = (state_q == LOAD) && first_q && (last_grant == REQ_B);

endmodule
